// File: rtl/calc_entry_fsm.sv
`default_nettype none
// ============================================================================
// calc_entry_fsm : keypad operand entry with digit-serial BCD add/subtract
// Rev 1.0
// ============================================================================
module calc_entry_fsm #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_press_i,
  input  logic                 is_num_i,
  input  logic                 is_op_i,
  input  logic                 is_eq_i,
  input  logic [3:0]           num_val_i,
  input  logic [1:0]           op_val_i,
  output logic [4*NDIGITS-1:0] disp_bcd_o,
  output logic                 disp_neg_o,
  output logic                 overflow_o,
  output logic                 busy_o,
  output logic                 result_valid_o
);
  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] C_FULL   = CW'(NDIGITS);
  localparam logic [IW-1:0] C_LAST   = IW'(NDIGITS - 1);
  localparam logic [1:0]    C_OP_ADD = 2'd1;
  localparam logic [1:0]    C_OP_SUB = 2'd2;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            btn_q;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]   cnta_q, cnta_d, cntb_q, cntb_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    ca_q, ca_d, cb_q, cb_d, res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d, neg_q, neg_d, ovf_q, ovf_d;
  logic [W-1:0]    disp_q, disp_d;
  logic            dneg_q, dneg_d, dovf_q, dovf_d, busy_q, busy_d, rv_q, rv_d;

  logic            w_ev, w_op_ok, w_app_a, w_app_b, w_c;
  logic [4:0]      w_sum, w_fix;
  logic [3:0]      w_dig;

  function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] x);
    logic [CW-1:0] n;
    n = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (x[4*k +: 4] != 4'd0) n = CW'(k + 1);
    end
    return n;
  endfunction

  assign w_ev    = btn_press_i & ~btn_q;
  assign w_op_ok = (op_val_i == C_OP_ADD) || (op_val_i == C_OP_SUB);
  // leading zeros never enter an operand and never consume a digit slot
  assign w_app_a = (cnta_q != C_FULL) && !((opa_q == '0) && (num_val_i == 4'd0));
  assign w_app_b = (cntb_q != C_FULL) && !((opb_q == '0) && (num_val_i == 4'd0));

  always_comb begin
    w_sum = 5'd0;
    w_fix = 5'd0;
    w_dig = 4'd0;
    w_c   = 1'b0;
    if (!sub_q) begin
      w_sum = {1'b0, ca_q[3:0]} + {1'b0, cb_q[3:0]} + {4'd0, cy_q};
      w_fix = w_sum - 5'd10;
      w_c   = (w_sum > 5'd9);
      w_dig = w_c ? w_fix[3:0] : w_sum[3:0];
    end else begin
      w_sum = {1'b0, ca_q[3:0]} - {1'b0, cb_q[3:0]} - {4'd0, cy_q};
      w_fix = w_sum + 5'd10;
      w_c   = w_sum[4];
      w_dig = w_c ? w_fix[3:0] : w_sum[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnta_d  = cnta_q;
    cntb_d  = cntb_q;
    sub_d   = sub_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    rv_d    = 1'b0;
    case (state_q)
      S_A: begin
        if (w_ev && is_num_i) begin
          if (w_app_a) begin
            opa_d  = {opa_q[W-5:0], num_val_i};
            cnta_d = cnta_q + CW'(1);
          end
        end else if (w_ev && is_op_i && w_op_ok) begin
          sub_d   = (op_val_i == C_OP_SUB);
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (w_ev && is_num_i) begin
          opb_d   = W'(num_val_i);
          cntb_d  = (num_val_i != 4'd0) ? CW'(1) : '0;
          state_d = S_B;
        end else if (w_ev && is_op_i && w_op_ok) begin
          sub_d = (op_val_i == C_OP_SUB);
        end
      end
      S_B: begin
        if (w_ev && is_num_i) begin
          if (w_app_b) begin
            opb_d  = {opb_q[W-5:0], num_val_i};
            cntb_d = cntb_q + CW'(1);
          end
        end else if (w_ev && is_eq_i) begin
          state_d = S_CALC;
          idx_d   = '0;
          cy_d    = 1'b0;
          res_d   = '0;
          ovf_d   = 1'b0;
          // subtraction always runs larger-minus-smaller; sign is kept aside
          if (sub_q && (opa_q < opb_q)) begin
            ca_d  = opb_q;
            cb_d  = opa_q;
            neg_d = 1'b1;
          end else begin
            ca_d  = opa_q;
            cb_d  = opb_q;
            neg_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        ca_d  = ca_q >> 4;
        cb_d  = cb_q >> 4;
        res_d = {w_dig, res_q[W-1:4]};
        cy_d  = w_c;
        idx_d = idx_q + IW'(1);
        if (idx_q == C_LAST) begin
          state_d = S_RES;
          rv_d    = 1'b1;
          ovf_d   = ~sub_q & w_c;
        end
      end
      S_RES: begin
        if (w_ev && is_num_i) begin
          opa_d   = W'(num_val_i);
          cnta_d  = (num_val_i != 4'd0) ? CW'(1) : '0;
          opb_d   = '0;
          cntb_d  = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_A;
        end else if (w_ev && is_op_i && w_op_ok && !neg_q && !ovf_q) begin
          opa_d   = res_q;
          cnta_d  = sig_digits(res_q);
          sub_d   = (op_val_i == C_OP_SUB);
          state_d = S_OP;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_comb begin
    disp_d = '0;
    case (state_d)
      S_A, S_OP:   disp_d = opa_d;
      S_B, S_CALC: disp_d = opb_d;
      S_RES:       disp_d = res_d;
      default:     disp_d = '0;
    endcase
    dneg_d = (state_d == S_RES) & neg_d;
    dovf_d = (state_d == S_RES) & ovf_d;
    busy_d = (state_d == S_CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      btn_q   <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      cnta_q  <= '0;
      cntb_q  <= '0;
      sub_q   <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      dneg_q  <= 1'b0;
      dovf_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_press_i;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnta_q  <= cnta_d;
      cntb_q  <= cntb_d;
      sub_q   <= sub_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      dneg_q  <= dneg_d;
      dovf_q  <= dovf_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
    end
  end

  assign disp_bcd_o     = disp_q;
  assign disp_neg_o     = dneg_q;
  assign overflow_o     = dovf_q;
  assign busy_o         = busy_q;
  assign result_valid_o = rv_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
`default_nettype none
// ============================================================================
// tb_calc_entry_fsm : keypad-sequence bench against a decimal calculator model
// Rev 1.0
// ============================================================================
module tb_calc_entry_fsm;
  localparam int N = 4;
  localparam int W = 4 * N;
  localparam int PH_A = 0, PH_OP = 1, PH_B = 2, PH_CALC = 3, PH_RES = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn = 1'b0, isn = 1'b0, iso = 1'b0, ise = 1'b0;
  logic [3:0]   nv  = 4'd0;
  logic [1:0]   ov  = 2'd0;
  logic [W-1:0] disp;
  logic         neg, ovf, busy, rv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.NDIGITS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_press_i   (btn),
    .is_num_i      (isn),
    .is_op_i       (iso),
    .is_eq_i       (ise),
    .num_val_i     (nv),
    .op_val_i      (ov),
    .disp_bcd_o    (disp),
    .disp_neg_o    (neg),
    .overflow_o    (ovf),
    .busy_o        (busy),
    .result_valid_o(rv)
  );

  // decimal-integer calculator model
  int           ph = PH_A, ma = 0, mb = 0, mr = 0, mcalc = 0;
  bit           msub = 0, mneg = 0, movf = 0, mbtn = 1, mvalid = 0;
  logic [W-1:0] e_disp = '0;
  bit           e_neg = 0, e_ovf = 0, e_busy = 0, e_rv = 0;

  function automatic int ndig(input int v);
    int n = 0;
    while (v > 0) begin n++; v = v / 10; end
    return n;
  endfunction

  function automatic int enter(input int x, input int d);
    if (ndig(x) >= N) return x;
    return x * 10 + d;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    bit ev, okop;
    int lim;
    lim  = 10 ** N;
    ev   = btn && !mbtn;
    mbtn = btn;
    okop = (ov == 2'd1) || (ov == 2'd2);
    e_rv = 0;
    if (rst) begin
      ph = PH_A; ma = 0; mb = 0; mr = 0; msub = 0; mneg = 0; movf = 0;
      mbtn = 1; mvalid = 1;
    end else if (ph == PH_CALC) begin
      mcalc++;
      if (mcalc == N) begin ph = PH_RES; e_rv = 1; end
    end else if (ev) begin
      case (ph)
        PH_A:  if (isn) ma = enter(ma, int'(nv));
               else if (iso && okop) begin msub = (ov == 2'd2); ph = PH_OP; end
        PH_OP: if (isn) begin mb = int'(nv); ph = PH_B; end
               else if (iso && okop) msub = (ov == 2'd2);
        PH_B:  if (isn) mb = enter(mb, int'(nv));
               else if (ise) begin
                 if (!msub) begin
                   mr = ma + mb; movf = (mr >= lim); mr = mr % lim; mneg = 0;
                 end else begin
                   mneg = (ma < mb); mr = mneg ? mb - ma : ma - mb; movf = 0;
                 end
                 mcalc = 0; ph = PH_CALC;
               end
        PH_RES: if (isn) begin ma = int'(nv); mneg = 0; movf = 0; ph = PH_A; end
                else if (iso && okop && !mneg && !movf) begin
                  ma = mr; msub = (ov == 2'd2); ph = PH_OP;
                end
        default: ;
      endcase
    end
    e_disp = to_bcd((ph == PH_A || ph == PH_OP) ? ma : (ph == PH_RES) ? mr : mb);
    e_neg  = (ph == PH_RES) && mneg;
    e_ovf  = (ph == PH_RES) && movf;
    e_busy = (ph == PH_CALC);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      n_cmp++;
      if (disp !== e_disp || neg !== e_neg || ovf !== e_ovf || busy !== e_busy || rv !== e_rv) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got disp=%h neg=%b ovf=%b busy=%b rv=%b, want disp=%h neg=%b ovf=%b busy=%b rv=%b",
                 $time, disp, neg, ovf, busy, rv, e_disp, e_neg, e_ovf, e_busy, e_rv);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [W-1:0] d, input bit n, input bit o);
    n_cmp++;
    if (disp !== d || neg !== n || ovf !== o) begin
      n_bad++;
      $display("FAIL %s: got disp=%h neg=%b ovf=%b, want disp=%h neg=%b ovf=%b", nm, disp, neg, ovf, d, n, o);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input bit want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic key(input bit n, input bit o, input bit e, input logic [3:0] v,
                     input logic [1:0] op, input int hold, input int gap);
    @(negedge clk);
    isn = n; iso = o; ise = e; nv = v; ov = op; btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0; isn = 1'b0; iso = 1'b0; ise = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic num(input logic [3:0] d); key(1, 0, 0, d, 2'd0, 2, 6); endtask
  task automatic opk(input logic [1:0] o); key(0, 1, 0, 4'd0, o, 2, 6); endtask
  task automatic eqk();                    key(0, 0, 1, 4'd0, 2'd0, 2, 6); endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic eq_timed(input string nm);
    logic b1, r4, r5;
    @(negedge clk);
    ise = 1'b1; btn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin btn = 1'b0; ise = 1'b0; end
      if (k == 1) b1 = busy;
      if (k == 4) r4 = rv;
      if (k == 5) r5 = rv;
    end
    check_bit({nm, "_busy_n1"}, b1, 1'b1);
    check_bit({nm, "_rv_n4"},   r4, 1'b0);
    check_bit({nm, "_rv_n5"},   r5, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_lit("reset", 16'h0000, 0, 0);

    num(1); num(2); opk(1); num(7);
    eq_timed("add12p7");
    check_lit("add12p7", 16'h0019, 0, 0);
    eqk();
    check_lit("eq_no_repeat", 16'h0019, 0, 0);

    do_reset();
    num(5); opk(2); num(8); eqk();
    check_lit("sub5m8", 16'h0003, 1, 0);
    opk(1);
    check_lit("op_after_neg", 16'h0003, 1, 0);
    num(4);
    check_lit("new_after_neg", 16'h0004, 0, 0);
    num(5);
    check_lit("append_after_res", 16'h0045, 0, 0);

    do_reset();
    num(9); num(9); num(9); num(9); opk(1); num(1); eqk();
    check_lit("ovf9999p1", 16'h0000, 0, 1);
    opk(1);
    check_lit("op_after_ovf", 16'h0000, 0, 1);

    do_reset();
    num(1); num(2); num(3); num(4); num(5);
    check_lit("five_digits", 16'h1234, 0, 0);

    do_reset();
    num(0); num(0); num(7);
    check_lit("lead_zero", 16'h0007, 0, 0);
    num(1); num(2); num(3); num(4);
    check_lit("lead_zero_count", 16'h7123, 0, 0);

    do_reset();
    key(1, 0, 0, 4'd3, 2'd0, 40, 4);
    check_lit("held_40", 16'h0003, 0, 0);

    do_reset();
    num(1); opk(3); opk(0); num(2); eqk();
    check_lit("invalid_op", 16'h0012, 0, 0);

    do_reset();
    num(9); opk(1); opk(2); num(6); eqk();
    check_lit("op_replace", 16'h0003, 0, 0);
    opk(1); num(2); eqk();
    check_lit("chain", 16'h0005, 0, 0);

    do_reset();
    num(1); num(0); num(0); num(0); opk(2); num(1); eqk();
    check_lit("borrow_chain", 16'h0999, 0, 0);

    do_reset();
    num(1); opk(1); num(1);
    key(0, 0, 1, 4'd0, 2'd0, 1, 1);
    key(1, 0, 0, 4'd7, 2'd0, 1, 8);
    check_lit("busy_drop", 16'h0002, 0, 0);

    do_reset();
    num(6); opk(1); num(5);
    key(0, 0, 1, 4'd0, 2'd0, 1, 1);
    rst = 1'b1;
    @(negedge clk);
    check_lit("rst_mid_calc", 16'h0000, 0, 0);
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_rv",   rv,   1'b0);
    isn = 1'b1; nv = 4'd5; btn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b0; isn = 1'b0;
    repeat (3) @(negedge clk);
    check_lit("held_through_rst", 16'h0000, 0, 0);
    num(8);
    check_lit("after_held_release", 16'h0008, 0, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
